// File: rtl/s_sub_seq.sv
// s_sub_seq: bit-serial subtractor, Y = A - B, one bit per clock, LSB first.
// The minuend and the zero-extended subtrahend are shifted out of two shift
// registers; each difference bit enters the result register at its MSB, so
// after P steps the result register holds the full difference.
// Optional feature: define S_SUB_SEQ_SAT_EN to clamp Y to zero on underflow.
// Without it, Y wraps modulo 2^P and no clamping logic exists.
module s_sub_seq #(
  parameter int P = 8,  // minuend / result width
  parameter int W = 5   // subtrahend width, W <= P
) (
  input  logic         CLK,
  input  logic         RST,    // asynchronous, active low
  input  logic         START,
  input  logic [P-1:0] A,
  input  logic [W-1:0] B,
  output logic [P-1:0] Y,
  output logic         UF,
  output logic         BUSY,
  output logic         DONE
);

  localparam int CW = (P > 1) ? $clog2(P) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [P-1:0]   r_a;
  logic [P-1:0]   r_b;
  logic [P-1:0]   r_res;
  logic [P-1:0]   r_y;
  logic           r_uf;
  logic           r_borrow;
  logic [CW-1:0]  r_cnt;

  logic           w_accept;
  logic           w_last;
  logic           w_a_bit;
  logic           w_b_bit;
  logic           w_diff;
  logic           w_borrow_next;
  logic [P-1:0]   w_res_next;
  logic [P-1:0]   w_y_final;

  // One full-subtractor cell applied to the current LSBs.
  assign w_a_bit       = r_a[0];
  assign w_b_bit       = r_b[0];
  assign w_diff        = w_a_bit ^ w_b_bit ^ r_borrow;
  assign w_borrow_next = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_borrow);
  assign w_res_next    = {w_diff, r_res[P-1:1]};
  assign w_last        = (r_cnt == CW'(P - 1));

`ifdef S_SUB_SEQ_SAT_EN
  // Clamp to zero when the final borrow signals A < B.
  assign w_y_final = w_borrow_next ? '0 : w_res_next;
`else
  // Plain modulo-2^P wrap.
  assign w_y_final = w_res_next;
`endif

  assign Y  = r_y;
  assign UF = r_uf;

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and Moore outputs; START is only looked at in IDLE.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    BUSY         = 1'b0;
    DONE         = 1'b0;
    case (r_state)
      IDLE: begin
        if (START) begin
          w_accept     = 1'b1;
          w_state_next = CALC;
        end
      end
      CALC: begin
        BUSY = 1'b1;
        if (w_last) begin
          w_state_next = FIN;
        end
      end
      FIN: begin
        DONE         = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Datapath: capture operands on accept, shift one bit per CALC cycle,
  // publish Y/UF on the step that handles the top bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_y      <= '0;
      r_uf     <= 1'b0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a      <= A;
      r_b      <= P'(B);
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == CALC) begin
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_res    <= w_res_next;
      r_borrow <= w_borrow_next;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) begin
        r_y  <= w_y_final;
        r_uf <= w_borrow_next;
      end
    end
  end

endmodule

// File: tb/tb_s_sub_seq.sv
// Self-checking bench for s_sub_seq (default P=8, W=5). Expected results are
// computed arithmetically, queued when an operation is launched and popped
// when DONE is seen.
module tb_s_sub_seq;

  localparam int P = 8;
  localparam int W = 5;

  logic         CLK = 1'b0;
  logic         RST;
  logic         START;
  logic [P-1:0] A;
  logic [W-1:0] B;
  logic [P-1:0] Y;
  logic         UF;
  logic         BUSY;
  logic         DONE;

  int checks   = 0;
  int failures = 0;

  logic [P:0] sb_q[$];  // {uf, y}

  s_sub_seq #(.P(P), .W(W)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .START(START),
    .A    (A),
    .B    (B),
    .Y    (Y),
    .UF   (UF),
    .BUSY (BUSY),
    .DONE (DONE)
  );

  always #5 CLK = ~CLK;

  // Reference result from plain arithmetic.
  function automatic logic [P:0] model(input logic [P-1:0] a, input logic [W-1:0] b);
    logic [P-1:0] bz;
    logic [P-1:0] y;
    logic         uf;
    bz = P'(b);
    uf = (a < bz);
    y  = a - bz;
`ifdef S_SUB_SEQ_SAT_EN
    if (uf) y = '0;
`endif
    return {uf, y};
  endfunction

  // Launch an operation; returns just after the accepting edge.
  task automatic start_op(input logic [P-1:0] a, input logic [W-1:0] b,
                          input bit hold, input bit push);
    A     = a;
    B     = b;
    START = 1'b1;
    if (push) sb_q.push_back(model(a, b));
    @(posedge CLK);
    #1;
    if (!hold) START = 1'b0;
  endtask

  // Wait (bounded) for DONE; counts edges after accept and BUSY cycles.
  task automatic wait_done(output int edges, output int busy_n, output bit timeout);
    busy_n  = BUSY ? 1 : 0;
    edges   = 0;
    timeout = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge CLK);
      #1;
      edges = i;
      if (DONE) begin
        timeout = 1'b0;
        break;
      end
      if (BUSY) busy_n++;
    end
  endtask

  task automatic test_reset();
    RST   = 1'b0;
    START = 1'b0;
    A     = '0;
    B     = '0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (Y !== 8'h00) begin failures++; $display("FAIL reset_y got=%h want=00", Y); end
    checks++; if (UF !== 1'b0) begin failures++; $display("FAIL reset_uf got=%b want=0", UF); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", BUSY); end
    checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", DONE); end
    RST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_basic();
    int e, bn;
    bit to;
    logic [P:0] exp;
    start_op(8'h04, 5'h04, 1'b0, 1'b1);
    checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL basic_busy_start got=%b want=1", BUSY); end
    wait_done(e, bn, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL basic_timeout got=%b want=0", to); end
    checks++; if (e != P) begin failures++; $display("FAIL basic_latency got=%0d want=%0d", e, P); end
    checks++; if (bn != P) begin failures++; $display("FAIL basic_busy_cycles got=%0d want=%0d", bn, P); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL basic_busy_in_fin got=%b want=0", BUSY); end
    exp = sb_q.pop_front();
    $display("op a=04 b=04 y=%h uf=%b", Y, UF);
    checks++; if (Y !== exp[P-1:0]) begin failures++; $display("FAIL basic_y got=%h want=%h", Y, exp[P-1:0]); end
    checks++; if (UF !== exp[P]) begin failures++; $display("FAIL basic_uf got=%b want=%b", UF, exp[P]); end
    @(posedge CLK);
    #1;
    checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b want=0", DONE); end
    checks++; if (Y !== exp[P-1:0]) begin failures++; $display("FAIL basic_y_hold got=%h want=%h", Y, exp[P-1:0]); end
  endtask

  task automatic test_underflow();
    int e, bn;
    bit to;
    logic [P:0] exp;
    start_op(8'h02, 5'h03, 1'b0, 1'b1);
    wait_done(e, bn, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL uf_timeout got=%b want=0", to); end
    exp = sb_q.pop_front();
    $display("op a=02 b=03 y=%h uf=%b", Y, UF);
    checks++; if (Y !== exp[P-1:0]) begin failures++; $display("FAIL uf_y got=%h want=%h", Y, exp[P-1:0]); end
    checks++; if (UF !== 1'b1) begin failures++; $display("FAIL uf_flag got=%b want=1", UF); end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_back_to_back();
    int e, bn, gap;
    bit to;
    logic [P:0] exp;
    start_op(8'hFF, 5'h1F, 1'b0, 1'b1);
    wait_done(e, bn, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL b2b_first_timeout got=%b want=0", to); end
    exp = sb_q.pop_front();
    $display("op a=ff b=1f y=%h uf=%b", Y, UF);
    checks++; if (Y !== 8'hE0 || Y !== exp[P-1:0]) begin failures++; $display("FAIL b2b_first_y got=%h want=e0", Y); end
    checks++; if (UF !== 1'b0) begin failures++; $display("FAIL b2b_first_uf got=%b want=0", UF); end
    // START held high from the FIN cycle on.
    A     = 8'h10;
    B     = 5'h01;
    START = 1'b1;
    sb_q.push_back(model(8'h10, 5'h01));
    gap = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge CLK);
      #1;
      if (DONE) begin
        gap = i;
        break;
      end
    end
    START = 1'b0;
    checks++; if (gap != P + 2) begin failures++; $display("FAIL b2b_gap got=%0d want=%0d", gap, P + 2); end
    exp = sb_q.pop_front();
    $display("op a=10 b=01 y=%h uf=%b", Y, UF);
    checks++; if (Y !== 8'h0F || Y !== exp[P-1:0]) begin failures++; $display("FAIL b2b_second_y got=%h want=0f", Y); end
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL b2b_no_third got=%b want=0", BUSY); end
  endtask

  task automatic test_ignore_start();
    int e, bn;
    bit to;
    logic [P:0] exp;
    start_op(8'h5A, 5'h07, 1'b0, 1'b1);
    START = 1'b1;
    A     = 8'hFF;
    B     = 5'h1F;
    wait_done(e, bn, to);
    START = 1'b0;
    checks++; if (to !== 1'b0 || e != P) begin failures++; $display("FAIL ign_latency got=%0d want=%0d", e, P); end
    exp = sb_q.pop_front();
    $display("op a=5a b=07 y=%h uf=%b", Y, UF);
    checks++; if (Y !== exp[P-1:0]) begin failures++; $display("FAIL ign_y got=%h want=%h", Y, exp[P-1:0]); end
    checks++; if (UF !== exp[P]) begin failures++; $display("FAIL ign_uf got=%b want=%b", UF, exp[P]); end
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL ign_no_restart got=%b want=0", BUSY); end
  endtask

  task automatic test_reset_mid();
    int e, bn;
    bit to, seen;
    logic [P:0] exp;
    start_op(8'h33, 5'h11, 1'b0, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL rmid_busy_before got=%b want=1", BUSY); end
    #2;
    RST = 1'b0;
    #1;
    checks++; if (Y !== 8'h00) begin failures++; $display("FAIL rmid_y got=%h want=00", Y); end
    checks++; if (UF !== 1'b0) begin failures++; $display("FAIL rmid_uf got=%b want=0", UF); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b want=0", BUSY); end
    checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL rmid_done got=%b want=0", DONE); end
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(posedge CLK);
      #1;
      if (i == 1) RST = 1'b1;
      if (DONE || BUSY) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rmid_activity got=%b want=0", seen); end
    start_op(8'h05, 5'h02, 1'b0, 1'b1);
    wait_done(e, bn, to);
    checks++; if (to !== 1'b0 || e != P) begin failures++; $display("FAIL rmid_latency got=%0d want=%0d", e, P); end
    exp = sb_q.pop_front();
    $display("op a=05 b=02 y=%h uf=%b", Y, UF);
    checks++; if (Y !== 8'h03 || Y !== exp[P-1:0]) begin failures++; $display("FAIL rmid_y_after got=%h want=03", Y); end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_random();
    int e, bn;
    bit to;
    logic [P:0] exp;
    logic [P-1:0] a;
    logic [W-1:0] b;
    for (int n = 0; n < 16; n++) begin
      case (n)
        0: begin a = 8'h00; b = 5'h1F; end
        1: begin a = 8'hFF; b = 5'h00; end
        2: begin a = 8'h00; b = 5'h00; end
        3: begin a = 8'h1F; b = 5'h1F; end
        default: begin
          a = 8'($urandom_range(0, 255));
          b = 5'($urandom_range(0, 31));
        end
      endcase
      start_op(a, b, 1'b0, 1'b1);
      wait_done(e, bn, to);
      exp = sb_q.pop_front();
      $display("op a=%h b=%h y=%h uf=%b", a, b, Y, UF);
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL rnd_timeout n=%0d got=%b want=0", n, to); end
      checks++; if ({UF, Y} !== exp) begin failures++; $display("FAIL rnd_result n=%0d got=%b/%h want=%b/%h", n, UF, Y, exp[P], exp[P-1:0]); end
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_random();
    checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d want=0", sb_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/s_sub_seq.md
S_SUB_SEQ -- requirements
Module: s_sub_seq

Interface
REQ-001 SHALL have parameter P, default 8, meaning minuend and result width in bits.
REQ-002 SHALL have parameter W, default 5, meaning subtrahend width in bits, with W <= P.
REQ-003 SHALL have port CLK  input  1  system clock; all state changes occur on the rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port START  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-006 SHALL have port A  input  P  minuend; captured on the accepting edge.
REQ-007 SHALL have port B  input  W  subtrahend; captured and zero-extended to P bits on the accepting edge.
REQ-008 SHALL have port Y  output  P  result A-B; held stable until the next DONE.
REQ-009 SHALL have port UF  output  1  underflow flag (A<B); updated together with Y.
REQ-010 SHALL have port BUSY  output  1  high while in state CALC.
REQ-011 SHALL have port DONE  output  1  one-cycle pulse marking Y/UF updated.

Function
REQ-012 SHALL implement an FSM with states IDLE, CALC, FIN.
REQ-013 IDLE with START=1 at an edge SHALL: load the A shift register, load the zero-extended B shift register, clear the borrow, clear the bit counter, and enter CALC.
REQ-014 CALC SHALL process one bit per edge, LSB first: diff = a^b^borrow; borrow_next = (~a&b) | (~(a^b)&borrow); diff is shifted into the result register MSB.
REQ-015 SHALL count the bit counter 0..P-1; on the edge processing bit P-1, CALC SHALL enter FIN and update Y and UF (UF = final borrow).
REQ-016 FIN SHALL hold DONE=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-017 Latency SHALL be P+1 edges from the accepting edge to DONE deasserting; DONE is high in the cycle following edge P.
REQ-018 START SHALL be ignored in CALC and FIN; A and B changes SHALL have no effect outside the accepting edge.
REQ-019 START held high continuously SHALL give back-to-back operations, one per P+2 cycles, with the next accept occurring in the IDLE cycle after FIN.
REQ-020 Y and UF SHALL retain their last values through IDLE and CALC until the next FIN update.
REQ-021 Without saturation, Y SHALL equal (A - B) mod 2^P.

Reset
REQ-022 RST=0 SHALL asynchronously force state IDLE and Y=0, UF=0, BUSY=0, DONE=0, with the counter, borrow and shift registers cleared.
REQ-023 Reset asserted mid-CALC SHALL abort the operation with no DONE pulse; after release, the first START SHALL be accepted normally.

Configuration
REQ-024 Macro S_SUB_SEQ_SAT_EN defined SHALL make the FIN update force Y=0 when the final borrow is 1 (UF still 1).
REQ-025 Macro S_SUB_SEQ_SAT_EN undefined SHALL make Y wrap modulo 2^P per REQ-021; the saturation logic SHALL not be present.

Verification
REQ-026 A=8'h04, B=5'h04, START pulse -> DONE after 8 edges, Y=8'h00, UF=0, BUSY high for exactly 8 cycles.
REQ-027 A=8'h02, B=5'h03 -> Y=8'hFF, UF=1 without the macro; Y=8'h00, UF=1 with S_SUB_SEQ_SAT_EN.
REQ-028 A=8'hFF, B=5'h1F -> Y=8'hE0, UF=0; then hold START high with A=8'h10, B=5'h01 -> second DONE exactly 10 cycles after the first, Y=8'h0F.
REQ-029 Drive START and change A/B during CALC -> no effect; the result matches the originally captured operands.
REQ-030 Assert RST at bit 3 of CALC -> all outputs 0 immediately, no DONE; a fresh A=8'h05, B=5'h02 operation then gives Y=8'h03.
